// File: rtl/bsg_assembler_out_deep.sv
// Wide-to-narrow output assembler: per-slice deep FIFOs drained round-robin onto the active channels.
// Optional build macro BSG_ASSEMBLER_OUT_DEEP_LOCKSTEP_EN selects all-or-nothing firing.
module bsg_assembler_out_deep #(
  parameter int width_p   = 8,
  parameter int num_in_p  = 4,
  parameter int num_out_p = 4,
  parameter int els_p     = 2,
  localparam int in_sel_w  = (num_in_p  > 1) ? $clog2(num_in_p)  : 1,
  localparam int out_sel_w = (num_out_p > 1) ? $clog2(num_out_p) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          calibration_done_i,
  input  logic                          valid_i,
  input  logic [num_in_p*width_p-1:0]   data_i,
  output logic                          ready_o,
  input  logic [in_sel_w-1:0]           in_top_channel_i,
  input  logic [out_sel_w-1:0]          out_top_channel_i,
  output logic [num_out_p-1:0]          valid_o,
  output logic [num_out_p*width_p-1:0]  data_o,
  input  logic [num_out_p-1:0]          ready_i,
  output logic                          drained_o
);

  localparam int ptr_w = $clog2(els_p);
  localparam int cnt_w = $clog2(els_p + 1);
  localparam int max_k = (num_in_p < num_out_p) ? num_in_p : num_out_p;

  logic [width_p-1:0]   mem    [num_in_p][els_p];
  logic [ptr_w-1:0]     rd_ptr [num_in_p];
  logic [ptr_w-1:0]     wr_ptr [num_in_p];
  logic [cnt_w-1:0]     cnt    [num_in_p];
  logic [in_sel_w-1:0]  in_ptr, in_ptr_n;
  logic [out_sel_w-1:0] out_ptr, out_ptr_n;
  logic                 rst_q;
  logic                 active;
  logic [num_in_p-1:0]  enq, deq;
  logic [in_sel_w-1:0]  src [max_k];
  logic [out_sel_w-1:0] dst [max_k];
  logic [max_k-1:0]     qual;
  logic [width_p-1:0]   ch_data [num_out_p];
  int unsigned          n_in, n_out, k_lim, k;

  function automatic logic [ptr_w-1:0] bump(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  // rst_q holds outputs quiet for the first cycle after reset
  assign active = calibration_done_i & ~reset & ~rst_q;

  always_comb begin : accept_logic
    n_in    = int'(in_top_channel_i) + 1;
    n_out   = int'(out_top_channel_i) + 1;
    k_lim   = (n_in < n_out) ? n_in : n_out;
    ready_o = active;
    for (int unsigned i = 0; i < num_in_p; i++)
      if (i < n_in && cnt[i] == cnt_w'(els_p)) ready_o = 1'b0;
    enq = '0;
    for (int unsigned i = 0; i < num_in_p; i++)
      enq[i] = valid_i & ready_o & (i < n_in);
  end

  always_comb begin : fire_logic
    int unsigned s, d;
    logic alive;
    qual = '0;
    for (int unsigned j = 0; j < max_k; j++) begin
      s = int'(in_ptr) + j;
      if (s >= n_in) s = s - n_in;
      d = int'(out_ptr) + j;
      if (d >= n_out) d = d - n_out;
      src[j]  = in_sel_w'(s);
      dst[j]  = out_sel_w'(d);
      qual[j] = active && (j < k_lim) && (cnt[src[j]] != '0) && ready_i[dst[j]];
    end
    k     = 0;
    alive = 1'b1;
    for (int unsigned j = 0; j < max_k; j++) begin
      if (alive && qual[j]) k = k + 1;
      else alive = 1'b0;
    end
`ifdef BSG_ASSEMBLER_OUT_DEEP_LOCKSTEP_EN
    if (k != k_lim) k = 0;
`endif
    deq     = '0;
    valid_o = '0;
    for (int unsigned c = 0; c < num_out_p; c++) ch_data[c] = '0;
    for (int unsigned j = 0; j < max_k; j++) begin
      if (j < k) begin
        deq[src[j]]     = 1'b1;
        valid_o[dst[j]] = 1'b1;
        ch_data[dst[j]] = mem[src[j]][rd_ptr[src[j]]];
      end
    end
    s = int'(in_ptr) + k;
    if (s >= n_in) s = s - n_in;
    d = int'(out_ptr) + k;
    if (d >= n_out) d = d - n_out;
    in_ptr_n  = in_sel_w'(s);
    out_ptr_n = out_sel_w'(d);
  end

  always_comb begin : pack_out
    data_o = '0;
    for (int unsigned c = 0; c < num_out_p; c++)
      data_o[c*width_p +: width_p] = ch_data[c];
  end

  always_comb begin : drain_flag
    drained_o = 1'b1;
    for (int unsigned i = 0; i < num_in_p; i++)
      if (cnt[i] != '0) drained_o = 1'b0;
    if (reset) drained_o = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rst_q   <= 1'b1;
      in_ptr  <= '0;
      out_ptr <= '0;
      for (int unsigned i = 0; i < num_in_p; i++) begin
        cnt[i]    <= '0;
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
      end
    end else begin
      rst_q <= 1'b0;
      if (!calibration_done_i) begin
        in_ptr  <= '0;
        out_ptr <= '0;
      end else begin
        in_ptr  <= in_ptr_n;
        out_ptr <= out_ptr_n;
      end
      for (int unsigned i = 0; i < num_in_p; i++) begin
        if (enq[i]) wr_ptr[i] <= bump(wr_ptr[i]);
        if (deq[i]) rd_ptr[i] <= bump(rd_ptr[i]);
        case ({enq[i], deq[i]})
          2'b10:   cnt[i] <= cnt[i] + 1'b1;
          2'b01:   cnt[i] <= cnt[i] - 1'b1;
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < num_in_p; i++)
      if (enq[i]) mem[i][wr_ptr[i]] <= data_i[i*width_p +: width_p];
  end

`ifndef SYNTHESIS
  logic [in_sel_w-1:0]  in_top_q;
  logic [out_sel_w-1:0] out_top_q;

  always_ff @(posedge clk) begin
    in_top_q  <= in_top_channel_i;
    out_top_q <= out_top_channel_i;
    if (!reset) begin
      assert (int'(in_top_channel_i) < num_in_p);
      assert (int'(out_top_channel_i) < num_out_p);
      assert (drained_o || (in_top_channel_i == in_top_q && out_top_channel_i == out_top_q));
    end
  end
`endif

endmodule

// File: tb/tb_bsg_assembler_out_deep.sv
// Directed bench for bsg_assembler_out_deep: vector table plus fill/drain sequences.
// Expectations for BSG_ASSEMBLER_OUT_DEEP_LOCKSTEP_EN builds are selected by the same macro.
module tb_bsg_assembler_out_deep;

  logic        clk = 1'b0;
  logic        reset, calibration_done_i, valid_i;
  logic [31:0] data_i;
  logic        ready_o;
  logic [1:0]  in_top_channel_i, out_top_channel_i;
  logic [3:0]  valid_o;
  logic [31:0] data_o;
  logic [3:0]  ready_i;
  logic        drained_o;

  int unsigned total = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  bsg_assembler_out_deep #(
    .width_p  (8),
    .num_in_p (4),
    .num_out_p(4),
    .els_p    (4)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .calibration_done_i(calibration_done_i),
    .valid_i           (valid_i),
    .data_i            (data_i),
    .ready_o           (ready_o),
    .in_top_channel_i  (in_top_channel_i),
    .out_top_channel_i (out_top_channel_i),
    .valid_o           (valid_o),
    .data_o            (data_o),
    .ready_i           (ready_i),
    .drained_o         (drained_o)
  );

  typedef struct {
    logic        rst, cal, v;
    logic [31:0] din;
    logic [1:0]  itop, otop;
    logic [3:0]  rdy;
    logic        e_rdy;
    logic [3:0]  e_val;
    logic [31:0] e_dat;
    logic        e_drn;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] WA  = 32'hA3A2A1A0;
  localparam logic [31:0] WB  = 32'hB3B2B1B0;
  localparam logic [31:0] WC  = 32'hC3C2C1C0;
  localparam logic [31:0] WD  = 32'hD3D2D1D0;
  localparam logic [31:0] WE  = 32'hE3E2E1E0;
  localparam logic [31:0] WF  = 32'hF3F2F1F0;
  localparam logic [31:0] WG  = 32'h13121110;
  localparam logic [31:0] WH  = 32'h23222120;
  localparam logic [31:0] W5A = 32'h00525150;
  localparam logic [31:0] W5B = 32'h00626160;
  localparam logic [31:0] W5C = 32'h00727170;

  task automatic add(input logic rst, cal, v, input logic [31:0] din,
                     input logic [1:0] itop, otop, input logic [3:0] rdy,
                     input logic e_rdy, input logic [3:0] e_val,
                     input logic [31:0] e_dat, input logic e_drn);
    vec_t t;
    t.rst = rst; t.cal = cal; t.v = v; t.din = din;
    t.itop = itop; t.otop = otop; t.rdy = rdy;
    t.e_rdy = e_rdy; t.e_val = e_val; t.e_dat = e_dat; t.e_drn = e_drn;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  initial begin
    logic [31:0] mask;
    logic [31:0] fillw [3];
    logic [7:0]  exp_stream [10];
    logic [7:0]  got [$];
    int unsigned acc;
    logic        any_valid, done;

    reset = 1'b1; calibration_done_i = 1'b1; valid_i = 1'b0; data_i = '0;
    in_top_channel_i = 2'd3; out_top_channel_i = 2'd3; ready_i = 4'hF;

    // reset and 4x4 back-to-back words
    add(1,1,0,0,  3,3,4'hF, 0,4'h0,0,1);
    add(0,1,1,WA, 3,3,4'hF, 0,4'h0,0,1);
    add(0,1,1,WA, 3,3,4'hF, 1,4'h0,0,1);
    add(0,1,1,WB, 3,3,4'hF, 1,4'hF,WA,0);
    add(0,1,0,0,  3,3,4'hF, 1,4'hF,WB,0);
    add(0,1,0,0,  3,3,4'hF, 1,4'h0,0,1);
    // 4 slices onto 2 channels
    add(0,1,1,WA, 3,1,4'hF, 1,4'h0,0,1);
    add(0,1,1,WB, 3,1,4'hF, 1,4'h3,32'h0000A1A0,0);
    add(0,1,0,0,  3,1,4'hF, 1,4'h3,32'h0000A3A2,0);
    add(0,1,0,0,  3,1,4'hF, 1,4'h3,32'h0000B1B0,0);
    add(0,1,0,0,  3,1,4'hF, 1,4'h3,32'h0000B3B2,0);
    add(0,1,0,0,  3,1,4'hF, 1,4'h0,0,1);
    // 3 slices onto 4 channels with ch2 stalled
    add(0,1,1,WC, 2,3,4'b1011, 1,4'h0,0,1);
`ifdef BSG_ASSEMBLER_OUT_DEEP_LOCKSTEP_EN
    add(0,1,0,0,  2,3,4'b1011, 1,4'h0,0,0);
    add(0,1,0,0,  2,3,4'b1011, 1,4'h0,0,0);
    add(0,1,0,0,  2,3,4'hF,    1,4'b0111,32'h00C2C1C0,0);
`else
    add(0,1,0,0,  2,3,4'b1011, 1,4'b0011,32'h0000C1C0,0);
    add(0,1,0,0,  2,3,4'b1011, 1,4'h0,0,0);
    add(0,1,0,0,  2,3,4'hF,    1,4'b0100,32'h00C20000,0);
`endif
    add(0,0,0,0,  2,3,4'hF, 0,4'h0,0,1);
    // fill a 4-deep FIFO with no sink, then drain
    add(0,1,1,WD, 3,3,4'h0, 1,4'h0,0,1);
    add(0,1,1,WE, 3,3,4'h0, 1,4'h0,0,0);
    add(0,1,1,WF, 3,3,4'h0, 1,4'h0,0,0);
    add(0,1,1,WG, 3,3,4'h0, 1,4'h0,0,0);
    add(0,1,1,WH, 3,3,4'h0, 0,4'h0,0,0);
    add(0,1,1,WH, 3,3,4'hF, 0,4'hF,WD,0);
    add(0,1,1,WH, 3,3,4'hF, 1,4'hF,WE,0);
    add(0,1,0,0,  3,3,4'hF, 1,4'hF,WF,0);
    add(0,1,0,0,  3,3,4'hF, 1,4'hF,WG,0);
    add(0,1,0,0,  3,3,4'hF, 1,4'hF,WH,0);
    add(0,1,0,0,  3,3,4'hF, 1,4'h0,0,1);
    // 3 slices onto 2 channels, pointers walked to (2,1), calibration dropped
    add(0,1,1,W5A,2,1,4'b0001, 1,4'h0,0,1);
    add(0,1,0,0,  2,1,4'b0011, 1,4'b0011,32'h00005150,0);
`ifdef BSG_ASSEMBLER_OUT_DEEP_LOCKSTEP_EN
    add(0,1,1,W5B,2,1,4'b0011, 1,4'h0,0,0);
    add(0,1,0,0,  2,1,4'b0011, 1,4'b0011,32'h00006052,0);
`else
    add(0,1,1,W5B,2,1,4'b0011, 1,4'b0001,32'h00000052,0);
    add(0,1,0,0,  2,1,4'b0011, 1,4'b0011,32'h00006061,0);
`endif
    add(0,0,1,32'hDEADBEEF,2,1,4'b0011, 0,4'h0,0,0);
    add(0,1,1,W5C,2,1,4'b0000, 1,4'h0,0,0);
`ifdef BSG_ASSEMBLER_OUT_DEEP_LOCKSTEP_EN
    add(0,1,0,0,  2,1,4'b0011, 1,4'b0011,32'h00006170,0);
    add(0,1,0,0,  2,1,4'b0011, 1,4'h0,0,0);
`else
    add(0,1,0,0,  2,1,4'b0011, 1,4'b0011,32'h00007170,0);
    add(0,1,0,0,  2,1,4'b0011, 1,4'b0001,32'h00000062,0);
`endif
    // reset with words buffered, then a fresh word
    add(0,1,1,32'h00454443,2,1,4'h0, 1,4'h0,0,0);
    add(0,1,1,32'h00555453,2,1,4'h0, 1,4'h0,0,0);
    add(1,1,1,32'h00656463,2,1,4'hF, 0,4'h0,0,1);
    add(0,1,0,0,  2,1,4'hF, 0,4'h0,0,1);
    add(0,1,1,32'h00838281,2,1,4'hF, 1,4'h0,0,1);
    add(0,1,0,0,  2,1,4'hF, 1,4'b0011,32'h00008281,0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst; calibration_done_i = vecs[i].cal; valid_i = vecs[i].v;
      data_i = vecs[i].din; in_top_channel_i = vecs[i].itop;
      out_top_channel_i = vecs[i].otop; ready_i = vecs[i].rdy;
      #1;
      mask = '0;
      for (int c = 0; c < 4; c++) if (vecs[i].e_val[c]) mask[c*8 +: 8] = 8'hFF;
      check($sformatf("v%0d ready_o", i), {31'd0, ready_o}, {31'd0, vecs[i].e_rdy});
      check($sformatf("v%0d valid_o", i), {28'd0, valid_o}, {28'd0, vecs[i].e_val});
      check($sformatf("v%0d data_o", i), data_o & mask, vecs[i].e_dat);
      check($sformatf("v%0d drained_o", i), {31'd0, drained_o}, {31'd0, vecs[i].e_drn});
    end

    // slice2 still holds 0x83: only three more words fit before it is full
    fillw = '{32'h00929190, 32'h00A2A1A0, 32'h00B2B1B0};
    exp_stream = '{8'h83, 8'h90, 8'h91, 8'h92, 8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1, 8'hB2};
    acc = 0;
    any_valid = 1'b0;
    ready_i = 4'h0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      valid_i = 1'b1;
      data_i = (acc < 3) ? fillw[acc] : 32'h0;
      #1;
      if (valid_o != 4'h0) any_valid = 1'b1;
      if (ready_o) acc++;
      else break;
    end
    valid_i = 1'b0;
    check("fill_accept_count", acc, 3);
    check("fill_no_valid", {31'd0, any_valid}, 32'd0);

    ready_i = 4'hF;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      #1;
      if (drained_o) done = 1'b1;
      else for (int c = 0; c < 2; c++) if (valid_o[c]) got.push_back(data_o[c*8 +: 8]);
    end
    check("drain_done", {31'd0, done}, 32'd1);
    check("drain_count", got.size(), 10);
    for (int i = 0; i < 10; i++)
      if (i < got.size()) check($sformatf("drain_word%0d", i), {24'd0, got[i]}, {24'd0, exp_stream[i]});
      else check($sformatf("drain_word%0d", i), 32'hFFFFFFFF, {24'd0, exp_stream[i]});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
